// File: rtl/spi_flash_reader_if.sv
// spi_flash_reader_if
//   Bundles the SPI pins and the read request/response stream of the
//   serial NOR flash reader.
//   master : the reader itself (drives sck/cs_n/mosi and the response stream)
//   slave  : the environment (flash device, requester and consumer)
//   Signals:
//     sck, cs_n, mosi   SPI clock, chip select (active low), master out
//     miso              master in
//     rd_addr, rd_len   start address and word count minus one
//     rd_start          one-cycle read request
//     rd_busy, rd_done  transaction in progress / one-cycle completion pulse
//     rd_data, rd_valid, rd_ready   output word stream with backpressure
interface spi_flash_reader_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 24,
    parameter int LEN_WIDTH  = 8
);
    logic                  sck;
    logic                  cs_n;
    logic                  mosi;
    logic                  miso;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [LEN_WIDTH-1:0]  rd_len;
    logic                  rd_start;
    logic                  rd_busy;
    logic                  rd_done;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  rd_ready;

    modport master (
        output sck, cs_n, mosi, rd_busy, rd_done, rd_data, rd_valid,
        input  miso, rd_addr, rd_len, rd_start, rd_ready
    );

    modport slave (
        input  sck, cs_n, mosi, rd_busy, rd_done, rd_data, rd_valid,
        output miso, rd_addr, rd_len, rd_start, rd_ready
    );
endinterface

// File: rtl/spi_flash_reader.sv
// spi_flash_reader
//   SPI mode-0 master issuing the NOR flash READ (0x03) command: 8-bit opcode,
//   ADDR_WIDTH address bits MSB first, then a burst of rd_len+1 DATA_WIDTH-bit
//   words delivered MSB-first on a valid/ready stream. When a finished word
//   cannot be handed to the output register, sck is parked low and the divider
//   frozen, so no bit is lost or duplicated.
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    spi_flash_reader_if.master (SPI pins + request/response stream)
module spi_flash_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 24,
    parameter int CLK_DIV    = 4,
    parameter int LEN_WIDTH  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    spi_flash_reader_if.master bus
);
    localparam int TX_W  = 8 + ADDR_WIDTH;
    localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int BIT_W = $clog2(MAX_W) + 1;
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int DSL_W = $clog2(2 * CLK_DIV) + 1;
    localparam int WRD_W = LEN_WIDTH + 1;

    localparam logic [7:0]       CMD_READ  = 8'h03;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] CMD_LAST  = BIT_W'(7);
    localparam logic [BIT_W-1:0] ADDR_LAST = BIT_W'(ADDR_WIDTH - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [DSL_W-1:0] DSL_LAST  = DSL_W'(2 * CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CMD   = 3'd1,
        S_ADDR  = 3'd2,
        S_DATA  = 3'd3,
        S_STALL = 3'd4,
        S_DESEL = 3'd5
    } state_e;

    state_e                state_q, state_d;
    logic                  sck_q, sck_d;
    logic                  cs_n_q, cs_n_d;
    logic                  mosi_q, mosi_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [WRD_W-1:0]      word_q, word_d;
    logic [TX_W-1:0]       tx_q, tx_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic                  pend_q, pend_d;  // rx_q holds a finished word not yet in rd_data
    logic                  last_q, last_d;  // every word of the burst has been shifted in
    logic [DSL_W-1:0]      dsl_q, dsl_d;

    logic div_end_s;
    logic out_free_s;
    logic load_s;

    assign div_end_s  = (div_q == DIV_LAST);
    // The output register can take a word when empty or being drained this cycle.
    assign out_free_s = !valid_q || bus.rd_ready;
    assign load_s     = pend_q && out_free_s;

    // Next-state logic for the FSM, SPI pins, counters and output register.
    always_comb begin
        state_d = state_q;
        sck_d   = sck_q;
        cs_n_d  = cs_n_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        done_d  = done_q;
        valid_d = valid_q;
        data_d  = data_q;
        div_d   = div_q;
        bit_d   = bit_q;
        word_d  = word_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        len_d   = len_q;
        pend_d  = pend_q;
        last_d  = last_q;
        dsl_d   = dsl_q;

        if (load_s) begin
            data_d  = rx_q;
            valid_d = 1'b1;
            pend_d  = 1'b0;
        end else if (valid_q && bus.rd_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        case (state_q)
            S_IDLE: begin
                sck_d = 1'b0;
                if (done_q) begin
                    // Completion cycle: a request here is deliberately dropped.
                    done_d = 1'b0;
                    busy_d = 1'b0;
                end else if (bus.rd_start) begin
                    tx_d    = {CMD_READ, bus.rd_addr};
                    len_d   = bus.rd_len;
                    cs_n_d  = 1'b0;
                    mosi_d  = CMD_READ[7];
                    busy_d  = 1'b1;
                    div_d   = {DIV_W{1'b0}};
                    bit_d   = {BIT_W{1'b0}};
                    word_d  = {WRD_W{1'b0}};
                    last_d  = 1'b0;
                    state_d = S_CMD;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_CMD, S_ADDR: begin
                if (div_end_s) begin
                    div_d = {DIV_W{1'b0}};
                    sck_d = !sck_q;
                    if (sck_q) begin
                        // Falling edge: present the next opcode/address bit.
                        tx_d   = {tx_q[TX_W-2:0], 1'b0};
                        mosi_d = tx_q[TX_W-2];
                        if (state_q == S_CMD) begin
                            if (bit_q == CMD_LAST) begin
                                bit_d   = {BIT_W{1'b0}};
                                state_d = S_ADDR;
                            end else begin
                                bit_d = bit_q + BIT_W'(1);
                            end
                        end else if (bit_q == ADDR_LAST) begin
                            bit_d   = {BIT_W{1'b0}};
                            mosi_d  = 1'b0;
                            state_d = S_DATA;
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end else begin
                        tx_d = tx_q;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            S_DATA: begin
                mosi_d = 1'b0;
                if (div_end_s && !sck_q) begin
                    // A rising edge is due here.
                    if (last_q) begin
                        // Low half after the final bit is complete: release the flash.
                        cs_n_d  = 1'b1;
                        dsl_d   = {DSL_W{1'b0}};
                        state_d = S_DESEL;
                    end else if (pend_q && !out_free_s) begin
                        // Park sck low with the divider frozen at its terminal count.
                        state_d = S_STALL;
                    end else begin
                        sck_d = 1'b1;
                        div_d = {DIV_W{1'b0}};
                        rx_d  = {rx_q[DATA_WIDTH-2:0], bus.miso};
                        if (bit_q == DATA_LAST) begin
                            bit_d  = {BIT_W{1'b0}};
                            pend_d = 1'b1;
                            if (word_q == {1'b0, len_q}) begin
                                last_d = 1'b1;
                            end else begin
                                word_d = word_q + WRD_W'(1);
                            end
                        end else begin
                            bit_d = bit_q + BIT_W'(1);
                        end
                    end
                end else if (div_end_s) begin
                    sck_d = 1'b0;
                    div_d = {DIV_W{1'b0}};
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            S_STALL: begin
                // The pending word is loaded above as soon as the register frees;
                // the withheld rising edge then fires on the following cycle.
                if (out_free_s) begin
                    state_d = S_DATA;
                end else begin
                    state_d = S_STALL;
                end
            end

            S_DESEL: begin
                sck_d = 1'b0;
                if (dsl_q != DSL_LAST) begin
                    dsl_d = dsl_q + DSL_W'(1);
                end else begin
                    dsl_d = dsl_q;
                end
                if ((dsl_q == DSL_LAST) && !pend_q && (!valid_q || bus.rd_ready)) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DESEL;
                end
            end

            default: begin
                sck_d   = 1'b0;
                cs_n_d  = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers, asynchronously cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sck_q   <= 1'b0;
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= {DATA_WIDTH{1'b0}};
            div_q   <= {DIV_W{1'b0}};
            bit_q   <= {BIT_W{1'b0}};
            word_q  <= {WRD_W{1'b0}};
            tx_q    <= {TX_W{1'b0}};
            rx_q    <= {DATA_WIDTH{1'b0}};
            len_q   <= {LEN_WIDTH{1'b0}};
            pend_q  <= 1'b0;
            last_q  <= 1'b0;
            dsl_q   <= {DSL_W{1'b0}};
        end else begin
            state_q <= state_d;
            sck_q   <= sck_d;
            cs_n_q  <= cs_n_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            word_q  <= word_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            len_q   <= len_d;
            pend_q  <= pend_d;
            last_q  <= last_d;
            dsl_q   <= dsl_d;
        end
    end

    assign bus.sck      = sck_q;
    assign bus.cs_n     = cs_n_q;
    assign bus.mosi     = mosi_q;
    assign bus.rd_busy  = busy_q;
    assign bus.rd_done  = done_q;
    assign bus.rd_data  = data_q;
    assign bus.rd_valid = valid_q;
endmodule

// File: tb/tb_spi_flash_reader.sv
// tb_spi_flash_reader
//   Directed bench for spi_flash_reader. Instance A uses CLK_DIV=4, instance B
//   CLK_DIV=2. Each has a behavioural flash model that captures opcode/address
//   on sck rising edges and shifts data out on falling edges.
module tb_spi_flash_reader;
    localparam int DW = 16;
    localparam int AW = 24;
    localparam int LW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    // Free-running cycle counter used for timing measurements.
    always @(posedge clk) cyc <= cyc + 1;

    spi_flash_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) ifa ();
    spi_flash_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) ifb ();

    spi_flash_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLK_DIV(4), .LEN_WIDTH(LW)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa.master));
    spi_flash_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLK_DIV(2), .LEN_WIDTH(LW)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb.master));

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- flash model / monitor for instance A ----------------
    int          a_bits, a_pulses, a_cs_low, a_cs_rise, a_nbeats, a_ndone, a_mosi_bad, a_idx;
    int          a_busy_low;
    logic [31:0] a_tx;
    logic [15:0] a_mem   [0:3];
    logic [15:0] a_beats [0:7];
    logic        a_prev_sck, a_prev_cs, a_prev_mosi;

    // Flash A behaviour and bus observation, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            a_prev_sck = 1'b0;
            a_prev_cs  = 1'b1;
            ifa.miso   = 1'b0;
        end else begin
            if (a_prev_cs && !ifa.cs_n) begin
                a_bits = 0; a_pulses = 0; a_cs_low = 0; a_tx = 32'h0;
            end
            if (!a_prev_cs && ifa.cs_n) a_cs_rise++;
            if (!ifa.cs_n) a_cs_low++;
            if (a_prev_sck && ifa.sck && (ifa.mosi !== a_prev_mosi)) a_mosi_bad++;
            if (!a_prev_sck && ifa.sck) begin
                a_pulses++;
                if (a_bits < 32) a_tx = {a_tx[30:0], ifa.mosi};
                a_bits++;
            end
            if (a_prev_sck && !ifa.sck && a_bits >= 32) begin
                a_idx    = a_bits - 32;
                ifa.miso = a_mem[(a_idx / 16) % 4][15 - (a_idx % 16)];
            end
            if (ifa.rd_valid && ifa.rd_ready) begin
                if (a_nbeats < 8) a_beats[a_nbeats] = ifa.rd_data;
                a_nbeats++;
            end
            if (ifa.rd_done) a_ndone++;
            a_prev_sck  = ifa.sck;
            a_prev_cs   = ifa.cs_n;
            a_prev_mosi = ifa.mosi;
        end
    end

    // ---------------- flash model / monitor for instance B ----------------
    int          b_bits, b_pulses, b_cs_low, b_nbeats, b_bad, b_ndone, b_per_bad, b_idx;
    int          b_last_rise, b_last_acc, b_done_cyc;
    logic [15:0] b_word;
    logic        b_prev_sck, b_prev_cs;

    function automatic logic [15:0] wval(input int k);
        logic [7:0] kk;
        kk = k[7:0];
        return {kk, ~kk};
    endfunction

    // Flash B returns wval(n) as the n-th word and checks the sck period.
    always @(negedge clk) begin
        if (!rst_n) begin
            b_prev_sck = 1'b0;
            b_prev_cs  = 1'b1;
            ifb.miso   = 1'b0;
        end else begin
            if (b_prev_cs && !ifb.cs_n) begin
                b_bits = 0; b_pulses = 0; b_cs_low = 0;
            end
            if (!ifb.cs_n) b_cs_low++;
            if (!b_prev_sck && ifb.sck) begin
                if (b_pulses > 0 && (cyc - b_last_rise) != 4) b_per_bad++;
                b_last_rise = cyc;
                b_pulses++;
                b_bits++;
            end
            if (b_prev_sck && !ifb.sck && b_bits >= 32) begin
                b_idx    = b_bits - 32;
                b_word   = wval(b_idx / 16);
                ifb.miso = b_word[15 - (b_idx % 16)];
            end
            if (ifb.rd_valid && ifb.rd_ready) begin
                if (ifb.rd_data !== wval(b_nbeats)) b_bad++;
                b_nbeats++;
                b_last_acc = cyc;
            end
            if (ifb.rd_done) begin
                b_ndone++;
                b_done_cyc = cyc;
            end
            b_prev_sck = ifb.sck;
            b_prev_cs  = ifb.cs_n;
        end
    end

    task automatic clear_mon_a();
        a_nbeats = 0; a_ndone = 0; a_cs_rise = 0; a_mosi_bad = 0;
        a_pulses = 0; a_cs_low = 0; a_tx = 32'h0; a_busy_low = 0;
    endtask

    task automatic start_a(input logic [23:0] addr, input logic [7:0] len);
        @(posedge clk); #1;
        ifa.rd_addr  = addr;
        ifa.rd_len   = len;
        ifa.rd_start = 1'b1;
        @(posedge clk); #1;
        ifa.rd_start = 1'b0;
    endtask

    task automatic wait_done_a(input int budget, input string tag);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < budget) begin
            @(posedge clk); #1;
            n++;
            if (!ifa.rd_busy) a_busy_low++;
            if (ifa.rd_done) seen = 1'b1;
        end
        check_eq({tag, " done_seen"}, 64'(seen), 64'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    int p150, st_hi, st_cshi, st_chg, nwait;
    bit b_seen;

    initial begin
        ifa.rd_start = 1'b0; ifa.rd_addr = 24'h0; ifa.rd_len = 8'h0; ifa.rd_ready = 1'b0;
        ifb.rd_start = 1'b0; ifb.rd_addr = 24'h0; ifb.rd_len = 8'h0; ifb.rd_ready = 1'b0;
        b_nbeats = 0; b_bad = 0; b_ndone = 0; b_per_bad = 0;
        b_last_rise = 0; b_last_acc = 0; b_done_cyc = 0; b_pulses = 0; b_cs_low = 0;
        clear_mon_a();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst pins_a", {ifa.sck, ifa.cs_n, ifa.mosi, ifa.rd_busy, ifa.rd_done, ifa.rd_valid},
                 {6'b010000});
        check_eq("rst data_a", ifa.rd_data, 64'h0);
        check_eq("rst cs_n_b", ifb.cs_n, 64'd1);
        rst_n = 1'b1;

        // 1: single word
        clear_mon_a();
        a_mem[0] = 16'hA5C3;
        ifa.rd_ready = 1'b1;
        start_a(24'h123456, 8'd0);
        check_eq("t1 busy_after_accept", ifa.rd_busy, 64'd1);
        check_eq("t1 cs_n_after_accept", ifa.cs_n, 64'd0);
        check_eq("t1 mosi_first", ifa.mosi, 64'd0);
        wait_done_a(2000, "t1");
        check_eq("t1 cmd_addr", a_tx, 64'h03123456);
        check_eq("t1 beats", a_nbeats, 64'd1);
        check_eq("t1 data", a_beats[0], 64'hA5C3);
        check_eq("t1 pulses", a_pulses, 64'd48);
        check_eq("t1 cs_low", a_cs_low, 64'd388);
        check_eq("t1 done_count", a_ndone, 64'd1);
        check_eq("t1 mosi_stable", a_mosi_bad, 64'd0);
        check_eq("t1 busy_after_done", ifa.rd_busy, 64'd0);

        // 2: four-word burst, consumer always ready
        clear_mon_a();
        a_mem[0] = 16'h0001; a_mem[1] = 16'h0002; a_mem[2] = 16'h0003; a_mem[3] = 16'h0004;
        start_a(24'h000040, 8'd3);
        wait_done_a(3000, "t2");
        check_eq("t2 beats", a_nbeats, 64'd4);
        for (int i = 0; i < 4; i++) check_eq($sformatf("t2 beat%0d", i), a_beats[i], 64'(i + 1));
        check_eq("t2 pulses", a_pulses, 64'd96);
        check_eq("t2 cs_low", a_cs_low, 64'd772);
        check_eq("t2 cs_continuous", a_cs_rise, 64'd1);

        // 3: consumer holds off for 200 clk after the first beat appears
        clear_mon_a();
        a_mem[0] = 16'hBEEF; a_mem[1] = 16'h1234; a_mem[2] = 16'hC0DE;
        ifa.rd_ready = 1'b0;
        start_a(24'h000200, 8'd2);
        nwait = 0;
        while (!ifa.rd_valid && nwait < 2000) begin
            @(posedge clk); #1;
            nwait++;
        end
        check_eq("t3 first_valid", ifa.rd_valid, 64'd1);
        st_hi = 0; st_cshi = 0; st_chg = 0; p150 = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (i == 150) p150 = a_pulses;
            if (i >= 150) begin
                if (ifa.sck) st_hi++;
                if (ifa.cs_n) st_cshi++;
                if (ifa.rd_data !== 16'hBEEF) st_chg++;
            end
        end
        check_eq("t3 stall_sck_low", st_hi, 64'd0);
        check_eq("t3 stall_cs_low", st_cshi, 64'd0);
        check_eq("t3 stall_data_hold", st_chg, 64'd0);
        check_eq("t3 stall_pulses_mid", p150, 64'd64);
        check_eq("t3 stall_pulses_end", a_pulses, 64'd64);
        ifa.rd_ready = 1'b1;
        wait_done_a(3000, "t3");
        check_eq("t3 beats", a_nbeats, 64'd3);
        check_eq("t3 beat0", a_beats[0], 64'hBEEF);
        check_eq("t3 beat1", a_beats[1], 64'h1234);
        check_eq("t3 beat2", a_beats[2], 64'hC0DE);
        check_eq("t3 pulses", a_pulses, 64'd80);
        check_eq("t3 cs_continuous", a_cs_rise, 64'd1);

        // 4: second request during ADDR is ignored
        clear_mon_a();
        a_mem[0] = 16'h5A0F;
        start_a(24'h0ABCDE, 8'd0);
        for (int i = 0; i < 120; i++) begin
            @(posedge clk); #1;
            if (!ifa.rd_busy) a_busy_low++;
        end
        ifa.rd_addr = 24'hFFFFFF; ifa.rd_len = 8'd5; ifa.rd_start = 1'b1;
        @(posedge clk); #1;
        ifa.rd_start = 1'b0;
        wait_done_a(2000, "t4");
        check_eq("t4 cmd_addr", a_tx, 64'h030ABCDE);
        check_eq("t4 beats", a_nbeats, 64'd1);
        check_eq("t4 data", a_beats[0], 64'h5A0F);
        check_eq("t4 pulses", a_pulses, 64'd48);
        check_eq("t4 busy_held", a_busy_low, 64'd0);
        repeat (50) @(posedge clk);
        #1;
        check_eq("t4 no_second_txn", a_cs_low, 64'd388);
        check_eq("t4 done_count", a_ndone, 64'd1);

        // 5: asynchronous reset during ADDR, then a fresh read
        clear_mon_a();
        a_mem[0] = 16'h3C96;
        start_a(24'h765432, 8'd1);
        repeat (120) @(posedge clk);
        #1;
        check_eq("t5 cs_low_pre", ifa.cs_n, 64'd0);
        rst_n = 1'b0;
        #1;
        check_eq("t5 rst_pins", {ifa.cs_n, ifa.sck, ifa.rd_valid, ifa.rd_busy, ifa.mosi}, {5'b10000});
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_mon_a();
        start_a(24'h000100, 8'd0);
        wait_done_a(2000, "t5");
        check_eq("t5 cmd_addr", a_tx, 64'h03000100);
        check_eq("t5 beats", a_nbeats, 64'd1);
        check_eq("t5 data", a_beats[0], 64'h3C96);
        check_eq("t5 pulses", a_pulses, 64'd48);

        // 6: CLK_DIV=2, 256-word burst
        ifb.rd_ready = 1'b1;
        @(posedge clk); #1;
        ifb.rd_addr = 24'h00ABCD; ifb.rd_len = 8'hFF; ifb.rd_start = 1'b1;
        @(posedge clk); #1;
        ifb.rd_start = 1'b0;
        nwait  = 0;
        b_seen = 1'b0;
        while (!b_seen && nwait < 20000) begin
            @(posedge clk); #1;
            nwait++;
            if (ifb.rd_done) b_seen = 1'b1;
        end
        check_eq("t6 done_seen", 64'(b_seen), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check_eq("t6 beats", b_nbeats, 64'd256);
        check_eq("t6 bad_words", b_bad, 64'd0);
        check_eq("t6 sck_period", b_per_bad, 64'd0);
        check_eq("t6 pulses", b_pulses, 64'd4128);
        check_eq("t6 cs_low", b_cs_low, 64'd16514);
        check_eq("t6 done_count", b_ndone, 64'd1);
        check_eq("t6 done_after_accept", 64'(b_done_cyc > b_last_acc), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
